// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
//   Instruction-memory responder at the far end of the fetch path.
//   The responder is loaded through a write port while in LOAD.
//   After ld_done_i it serves word-aligned fetches with one-cycle latency.
//   The response is held stable while the consumer back-pressures it.
//   flush_i discards the pending response.
//   Memory contents survive rst_i; every other register is reset.
//
// Optional feature macro: IMEM_FETCH_CNT_EN
//   defined   : fetch_cnt_o counts accepted fetches and wraps at 2^32.
//   undefined : fetch_cnt_o is tied to zero.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   req_valid_i/ready_o   fetch request handshake, req_pc_i = byte PC
//   rsp_valid_o/ready_i   response handshake; rsp_instr_o, rsp_pc_o, rsp_err_o
//   flush_i               drop the pending response, block acceptance
//   ld_valid_i/addr/data  program-load write port (LOAD state only)
//   ld_done_i             end of program load, enters RUN
//   ld_err_o              sticky: a load write was dropped
//   running_o             high in RUN
//   fetch_cnt_o           accepted-fetch counter
//
// state  | meaning
// -------+-----------------------------------------------
// LOAD   | program load; fetches blocked, writes allowed
// RUN    | fetch service; memory read-only
module imem_fetch_responder #(
  parameter int DEPTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_pc_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_instr_o,
  output logic [31:0] rsp_pc_o,
  output logic        rsp_err_o,
  input  logic        flush_i,
  input  logic        ld_valid_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  input  logic        ld_done_i,
  output logic        ld_err_o,
  output logic        running_o,
  output logic [31:0] fetch_cnt_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_instr_q, rsp_instr_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        rsp_err_q, rsp_err_d;
  logic        ld_err_q, ld_err_d;

  logic [31:0] mem_q [DEPTH];

  logic running;
  logic ld_addr_ok;
  logic pc_err;
  logic accept;

  assign running = (state_q == ST_RUN);

  // In range means every bit above the word index is zero (addr < 4*DEPTH).
  assign ld_addr_ok = (ld_addr_i[1:0] == 2'b00) && (ld_addr_i[31:AW+2] == '0);
  assign pc_err     = (req_pc_i[1:0] != 2'b00) || (req_pc_i[31:AW+2] != '0);

  assign req_ready_o = running && !flush_i && (!rsp_valid_q || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  // No reset on the array: the loaded program must survive rst_i.
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_LOAD) && ld_valid_i && ld_addr_ok) begin
      mem_q[ld_addr_i[AW+1:2]] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_LOAD;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_pc_q    <= '0;
      rsp_err_q   <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_err_q   <= rsp_err_d;
      ld_err_q    <= ld_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_err_d   = rsp_err_q;
    ld_err_d    = ld_err_q;

    if (state_q == ST_LOAD) begin
      if (ld_valid_i && !ld_addr_ok) begin
        ld_err_d = 1'b1;
      end
      // A write in the same cycle as ld_done still lands; see the memory block.
      if (ld_done_i) begin
        state_d = ST_RUN;
      end
    end

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = req_pc_i;
      rsp_err_d   = pc_err;
      rsp_instr_d = pc_err ? 32'h0000_0000 : mem_q[req_pc_i[AW+1:2]];
    end else if (flush_i || rsp_ready_i) begin
      // Only the valid bit drops; the payload stays stable.
      rsp_valid_d = 1'b0;
    end
  end

`ifdef IMEM_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
    end else if (accept) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
`else
  assign fetch_cnt_o = '0;
`endif

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_instr_o = rsp_instr_q;
  assign rsp_pc_o    = rsp_pc_q;
  assign rsp_err_o   = rsp_err_q;
  assign ld_err_o    = ld_err_q;
  assign running_o   = running;

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_pc;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_instr, rsp_pc;
  logic        rsp_err, flush;
  logic        ld_valid;
  logic [31:0] ld_addr, ld_data;
  logic        ld_done, ld_err, running;
  logic [31:0] fetch_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_cnt;

  imem_fetch_responder #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_pc_i(req_pc),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_instr_o(rsp_instr), .rsp_pc_o(rsp_pc), .rsp_err_o(rsp_err),
    .flush_i(flush),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .ld_done_i(ld_done), .ld_err_o(ld_err), .running_o(running),
    .fetch_cnt_o(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Expected counter value as seen on the port for this build.
  function automatic logic [31:0] exp_fc();
`ifdef IMEM_FETCH_CNT_EN
    return exp_cnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_pc = 0; rsp_ready = 0; flush = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0; ld_done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_reset();
    req_valid = 1;
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b exp 0", req_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_instr !== 32'h0) $display("FAIL reset_rsp_instr: got %h exp 0", rsp_instr); else pass_cnt++;
    total_cnt++; if (rsp_pc !== 32'h0) $display("FAIL reset_rsp_pc: got %h exp 0", rsp_pc); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b exp 0", rsp_err); else pass_cnt++;
    total_cnt++; if (ld_err !== 1'b0) $display("FAIL reset_ld_err: got %b exp 0", ld_err); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("FAIL reset_running: got %b exp 0", running); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 32'h0) $display("FAIL reset_fetch_cnt: got %h exp 0", fetch_cnt); else pass_cnt++;
    req_valid = 0;
  endtask

  // Words 0..3, then two dropped writes, then word 4 written together with ld_done.
  task automatic test_load();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_addr = 4 * i; ld_data = 32'h1111_1111 * (i + 1);
      model_mem[i] = ld_data;
      tick();
    end
    total_cnt++; if (ld_err !== 1'b0) $display("FAIL load_good_ld_err: got %b exp 0", ld_err); else pass_cnt++;
    ld_addr = 32'h2; ld_data = 32'hDEAD_BEEF;
    tick();
    total_cnt++; if (ld_err !== 1'b1) $display("FAIL load_misaligned_ld_err: got %b exp 1", ld_err); else pass_cnt++;
    ld_addr = 32'h100; ld_data = 32'hBAD0_BAD0;
    req_valid = 1;
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL load_req_ready: got %b exp 0", req_ready); else pass_cnt++;
    tick();
    req_valid = 0;
    ld_addr = 32'h10; ld_data = 32'h5555_5555; ld_done = 1;
    model_mem[4] = ld_data;
    tick();
    ld_valid = 0; ld_done = 0;
    total_cnt++; if (running !== 1'b1) $display("FAIL load_running: got %b exp 1", running); else pass_cnt++;
    total_cnt++; if (ld_err !== 1'b1) $display("FAIL load_ld_err_sticky: got %b exp 1", ld_err); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1; req_valid = 1;
    for (int k = 0; k < 5; k++) begin
      req_pc = 4 * k;
      #1;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_req_ready[%0d]: got %b exp 1", k, req_ready); else pass_cnt++;
      tick();
      exp_cnt++;
      total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL b2b_rsp_valid[%0d]: got %b exp 1", k, rsp_valid); else pass_cnt++;
      total_cnt++; if (rsp_instr !== model_mem[k]) $display("FAIL b2b_rsp_instr[%0d]: got %h exp %h", k, rsp_instr, model_mem[k]); else pass_cnt++;
      total_cnt++; if (rsp_pc !== 32'(4 * k)) $display("FAIL b2b_rsp_pc[%0d]: got %h exp %h", k, rsp_pc, 4 * k); else pass_cnt++;
      total_cnt++; if (rsp_err !== 1'b0) $display("FAIL b2b_rsp_err[%0d]: got %b exp 0", k, rsp_err); else pass_cnt++;
    end
    req_valid = 0;
    tick();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL b2b_drain: got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== exp_fc()) $display("FAIL b2b_fetch_cnt: got %h exp %h", fetch_cnt, exp_fc()); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    req_valid = 1; req_pc = 32'h8; rsp_ready = 0;
    tick();
    exp_cnt++;
    req_pc = 32'hC;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b exp 0", c, req_ready); else pass_cnt++;
      total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_valid[%0d]: got %b exp 1", c, rsp_valid); else pass_cnt++;
      total_cnt++; if (rsp_instr !== 32'h3333_3333) $display("FAIL bp_rsp_instr[%0d]: got %h exp 33333333", c, rsp_instr); else pass_cnt++;
      total_cnt++; if (rsp_pc !== 32'h8) $display("FAIL bp_rsp_pc[%0d]: got %h exp 8", c, rsp_pc); else pass_cnt++;
      tick();
    end
    rsp_ready = 1;
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b exp 1", req_ready); else pass_cnt++;
    tick();
    exp_cnt++;
    total_cnt++; if (rsp_instr !== 32'h4444_4444) $display("FAIL bp_next_instr: got %h exp 44444444", rsp_instr); else pass_cnt++;
    total_cnt++; if (rsp_pc !== 32'hC) $display("FAIL bp_next_pc: got %h exp c", rsp_pc); else pass_cnt++;
    req_valid = 0;
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] pcs [4];
    logic        errs [4];
    pcs[0] = 32'h6;         errs[0] = 1;
    pcs[1] = 32'h100;       errs[1] = 1;
    pcs[2] = 32'h8000_0000; errs[2] = 1;
    pcs[3] = 32'hFC;        errs[3] = 0;
    rsp_ready = 1; req_valid = 1;
    for (int k = 0; k < 4; k++) begin
      req_pc = pcs[k];
      tick();
      exp_cnt++;
      total_cnt++; if (rsp_err !== errs[k]) $display("FAIL err_flag[%0d]: got %b exp %b", k, rsp_err, errs[k]); else pass_cnt++;
      total_cnt++; if (rsp_pc !== pcs[k]) $display("FAIL err_pc[%0d]: got %h exp %h", k, rsp_pc, pcs[k]); else pass_cnt++;
      if (errs[k]) begin
        total_cnt++; if (rsp_instr !== 32'h0) $display("FAIL err_instr[%0d]: got %h exp 0", k, rsp_instr); else pass_cnt++;
      end
    end
    req_valid = 0;
    tick();
    total_cnt++; if (fetch_cnt !== exp_fc()) $display("FAIL err_fetch_cnt: got %h exp %h", fetch_cnt, exp_fc()); else pass_cnt++;
  endtask

  task automatic test_flush();
    req_valid = 1; req_pc = 32'h0; rsp_ready = 0;
    tick();
    exp_cnt++;
    total_cnt++; if (rsp_instr !== 32'h1111_1111) $display("FAIL flush_pre_instr: got %h exp 11111111", rsp_instr); else pass_cnt++;
    flush = 1; req_pc = 32'h4;
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL flush_req_ready: got %b exp 0", req_ready); else pass_cnt++;
    tick();
    flush = 0; req_valid = 0;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL flush_rsp_valid: got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== exp_fc()) $display("FAIL flush_fetch_cnt: got %h exp %h", fetch_cnt, exp_fc()); else pass_cnt++;
  endtask

  task automatic test_reset_mid_fetch();
    req_valid = 1; req_pc = 32'h4; rsp_ready = 0;
    tick();
    #2;
    rst = 1;
    #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rstmid_rsp_valid: got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_instr !== 32'h0) $display("FAIL rstmid_rsp_instr: got %h exp 0", rsp_instr); else pass_cnt++;
    total_cnt++; if (rsp_pc !== 32'h0) $display("FAIL rstmid_rsp_pc: got %h exp 0", rsp_pc); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("FAIL rstmid_running: got %b exp 0", running); else pass_cnt++;
    total_cnt++; if (ld_err !== 1'b0) $display("FAIL rstmid_ld_err: got %b exp 0", ld_err); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL rstmid_req_ready: got %b exp 0", req_ready); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 32'h0) $display("FAIL rstmid_fetch_cnt: got %h exp 0", fetch_cnt); else pass_cnt++;
    @(negedge clk);
    rst = 0; req_valid = 0; exp_cnt = 0;
    ld_done = 1;
    tick();
    ld_done = 0;
    req_valid = 1; req_pc = 32'h4; rsp_ready = 1;
    tick();
    exp_cnt++;
    req_valid = 0;
    total_cnt++; if (rsp_instr !== 32'h2222_2222) $display("FAIL rstmid_retained: got %h exp 22222222", rsp_instr); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== exp_fc()) $display("FAIL rstmid_fetch_cnt_restart: got %h exp %h", fetch_cnt, exp_fc()); else pass_cnt++;
    tick();
  endtask

  // Random traffic against a transaction-level model of the response slot.
  task automatic test_random();
    logic        m_valid, m_err, exp_ready, acc;
    logic [31:0] m_instr, m_pc, pc;
    int          sel;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1; ld_addr = 4 * i; ld_data = $urandom;
      model_mem[i] = ld_data;
      ld_done = (i == DEPTH - 1);
      tick();
    end
    ld_valid = 0; ld_done = 0;
    m_valid = 0; m_err = 0; m_instr = 0; m_pc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       pc = 4 * $urandom_range(0, DEPTH - 1);
      else if (sel == 7) pc = 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      else if (sel == 8) pc = 4 * DEPTH + $urandom_range(0, 1023);
      else               pc = $urandom;
      req_pc    = pc;
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      exp_ready = !flush && (!m_valid || rsp_ready);
      acc       = req_valid && exp_ready;
      #1;
      total_cnt++; if (req_ready !== exp_ready) $display("FAIL rnd_req_ready[%0d]: got %b exp %b", cyc, req_ready, exp_ready); else pass_cnt++;
      tick();
      if (acc) begin
        m_valid = 1;
        m_pc    = pc;
        m_err   = (pc % 4 != 0) || (pc >= 4 * DEPTH);
        m_instr = m_err ? 32'h0 : model_mem[pc / 4];
        exp_cnt++;
      end else if (flush || rsp_ready) begin
        m_valid = 0;
      end
      total_cnt++; if (rsp_valid !== m_valid) $display("FAIL rnd_rsp_valid[%0d]: got %b exp %b", cyc, rsp_valid, m_valid); else pass_cnt++;
      if (m_valid) begin
        total_cnt++; if (rsp_instr !== m_instr) $display("FAIL rnd_rsp_instr[%0d]: got %h exp %h", cyc, rsp_instr, m_instr); else pass_cnt++;
        total_cnt++; if (rsp_pc !== m_pc) $display("FAIL rnd_rsp_pc[%0d]: got %h exp %h", cyc, rsp_pc, m_pc); else pass_cnt++;
        total_cnt++; if (rsp_err !== m_err) $display("FAIL rnd_rsp_err[%0d]: got %b exp %b", cyc, rsp_err, m_err); else pass_cnt++;
      end
    end
    idle_inputs();
    total_cnt++; if (fetch_cnt !== exp_fc()) $display("FAIL rnd_fetch_cnt: got %h exp %h", fetch_cnt, exp_fc()); else pass_cnt++;
  endtask

  initial begin
    exp_cnt = 0;
    idle_inputs();
    rst = 1;
    #12;
    test_reset();
    rst = 0;
    tick();
    test_load();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_flush();
    test_reset_mid_fetch();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Instruction-memory responder sitting at the far end of the processor's fetch path. Serves word-aligned PC fetch requests over a valid/ready handshake with one-cycle latency, holds the response under back-pressure, and is program-loaded through a separate write port before fetching is enabled. A `flush` input lets the branch logic discard an in-flight fetch.

## Interface
- `DEPTH`, 64, number of 32-bit instruction words; a power of two.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  responder accepts a request this cycle.
- `req_pc`  in  32  byte address of the instruction.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `rsp_instr`  out  32  fetched instruction word.
- `rsp_pc`  out  32  PC the response belongs to.
- `rsp_err`  out  1  misaligned or out-of-range fetch.
- `flush`  in  1  discard the pending response and block acceptance this cycle.
- `ld_valid`  in  1  program-load write strobe.
- `ld_addr`  in  32  byte address of load word.
- `ld_data`  in  32  load word.
- `ld_done`  in  1  end of program load.
- `ld_err`  out  1  sticky: a load was dropped.
- `running`  out  1  high in RUN state.
- `fetch_cnt`  out  32  accepted-fetch counter (see Configuration).

## Operation
- States: LOAD (reset state), RUN. LOAD -> RUN on `ld_done`=1 at a clock edge. RUN is left only by `rst`.
- LOAD: `req_ready`=0. On `ld_valid`, the word at index `ld_addr[log2(DEPTH)+1:2]` is written with `ld_data` if `ld_addr[1:0]`==0 and `ld_addr` < 4*DEPTH; otherwise the write is dropped and `ld_err` set. `ld_valid` and `ld_done` in the same cycle: the write is performed, then the state moves to RUN.
- RUN: `ld_valid` ignored, memory read-only.
- `req_ready` = running && !flush && (!rsp_valid || rsp_ready).
- Accept = req_valid && req_ready. On accept: `rsp_pc` <= `req_pc`; if `req_pc[1:0]`!=0 or `req_pc` >= 4*DEPTH then `rsp_err`<=1, `rsp_instr`<=32'h0000_0000 (NOP); else `rsp_err`<=0, `rsp_instr`<=mem[index]; `rsp_valid`<=1.
- No accept and rsp_ready: `rsp_valid`<=0. No accept and !rsp_ready: response held bit-stable.
- `flush`=1: `rsp_valid`<=0 at the edge, regardless of `rsp_ready`; no request accepted that cycle.
- Memory contents are not cleared by `rst`; reads of never-loaded words return undefined data and are not flagged.

## Timing
- Reset values: state LOAD, `req_ready` 0, `rsp_valid` 0, `rsp_instr` 0, `rsp_pc` 0, `rsp_err` 0, `ld_err` 0, `running` 0, `fetch_cnt` 0.
- Latency: request accepted at edge N -> `rsp_valid`=1 after edge N.
- Throughput: one fetch per cycle when `rsp_ready` held 1.
- `req_ready` is combinational from `rsp_ready`, `flush`, state; no combinational path from `req_*` to `rsp_*`.
- `rst` asserted mid-fetch: all outputs return to reset values immediately; the response is lost, loaded program kept.
- A load write at edge N is readable by a fetch accepted at any later edge (first possible fetch is N+1 after `ld_done`).

## Configuration
- `IMEM_FETCH_CNT_EN` defined: `fetch_cnt` increments by 1 on every accept (including error fetches), wraps 32'hFFFF_FFFF -> 0, cleared only by `rst`.
- Not defined: no counter register; `fetch_cnt` tied to 0.

## Test plan
- Load words 0..3 = 32'h1111_1111..32'h4444_4444, pulse `ld_done`, fetch PC 0,4,8,12 back-to-back with `rsp_ready`=1 -> four consecutive responses, data/PC match, one per cycle.
- Fetch PC 8 with `rsp_ready`=0 for 3 cycles -> `rsp_valid`=1, `rsp_instr`=32'h3333_3333 stable, `req_ready`=0; release -> consumed, next request accepted that cycle.
- Fetch PC 6 and PC 0x100 (DEPTH=64) -> each `rsp_err`=1, `rsp_instr`=0, `rsp_pc` echoed.
- Pending response plus `flush`=1 with `req_valid`=1 -> `rsp_valid`=0 next cycle, request not accepted, `fetch_cnt` unchanged.
- In LOAD, write `ld_addr`=0x2 -> `ld_err`=1, memory unchanged; `req_valid`=1 -> `req_ready`=0.
- Assert `rst` while `rsp_valid`=1 -> outputs at reset values asynchronously; re-enter RUN via `ld_done`, fetch PC 4 -> 32'h2222_2222 (program retained); with `IMEM_FETCH_CNT_EN`, counter restarts from 0.
